vdp_interrupt_controller: RTL and testbench
===========================================

VDP_INTERRUPT_CONTROLLER -- requirements
Module: vdp_interrupt_controller

Interface
REQ-001 SHALL have parameter TOP_LINE, default 9'd27; meaning: raw line count of display line 0 (NTSC 192/212 top border offset).
REQ-002 SHALL have parameter VBLANK_LINE, default 9'd212; meaning: display line at which the frame (V-blank) flag F is raised when reg_212lines=1 (192 when 0).
REQ-003 clk  input  1  system clock, single domain.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 frame_start  input  1  one-cycle pulse at raw line 0 of each field.
REQ-006 line_start  input  1  one-cycle pulse at start of each raw line.
REQ-007 reg_ie0  input  1  R#0 bit4, line interrupt enable.
REQ-008 reg_ie1  input  1  R#1 bit5, frame interrupt enable.
REQ-009 reg_212lines  input  1  R#9 bit7, LN.
REQ-010 reg_line_int  input  8  R#19, interrupt line.
REQ-011 reg_vscroll  input  8  R#23, vertical display offset.
REQ-012 status0_read  input  1  one-cycle pulse, CPU read of S#0 completed.
REQ-013 status1_read  input  1  one-cycle pulse, CPU read of S#1 completed.
REQ-014 status_f  output  1  S#0 bit7.
REQ-015 status_fh  output  1  S#1 bit0.
REQ-016 display_line  output  9  current display-relative line.
REQ-017 int_n  output  1  registered interrupt request to slot, active-low.

Function
REQ-018 Raw line counter (9 bit) SHALL clear on frame_start, else increment on line_start, saturating at 511.
REQ-019 display_line SHALL equal raw counter minus TOP_LINE, modulo 512, registered one cycle after counter update.
REQ-020 Compare pipeline: line_start at cycle N -> counter update N+1 -> display_line N+2 -> match evaluated N+2 -> status_fh set N+3 -> int_n low N+4.
REQ-021 Line match SHALL be ((display_line[7:0] + reg_vscroll) mod 256) == reg_line_int, and only while display_line < 256.
REQ-022 A match SHALL set status_fh at most once per line (edge-qualified by the line_start-derived strobe), regardless of reg_ie0.
REQ-023 status_f SHALL set once when display_line reaches VBLANK_LINE (or 192 if reg_212lines=0), regardless of reg_ie1.
REQ-024 status1_read SHALL clear status_fh next cycle; status0_read SHALL clear status_f next cycle.
REQ-025 Simultaneous set and read-clear of the same flag in one cycle: set SHALL win (event never lost).
REQ-026 int_n SHALL be registered ~((status_fh & reg_ie0) | (status_f & reg_ie1)); clearing an enable deasserts int_n next cycle without clearing the flag.
REQ-027 Change of reg_line_int or reg_vscroll SHALL take effect on the next compare; no retroactive set for already-passed lines.
REQ-028 frame_start and line_start in same cycle: frame_start SHALL take priority (counter = 0).

Reset
REQ-029 On reset: counter=0, display_line=9'h1FF-TOP_LINE+1 equivalent of raw 0, status_f=0, status_fh=0, int_n=1, pipeline valid bits=0.
REQ-030 Reset asserted mid-frame SHALL discard any in-flight match; no flag set within 4 cycles after reset release without a new line_start.

Structure
REQ-031 TOP_LINE and VBLANK_LINE defaults and 192/212 constants SHALL live in shared package vdp_package.
REQ-032 Single sub-module vdp_line_counter (REQ-018/019/028) SHALL be instantiated; flags and int_n logic stay in the top.

Verification
REQ-033 reg_line_int=69, reg_vscroll=0, ie0=0: after line_start for display line 69 -> status_fh=1 at N+3, int_n stays 1; status1_read -> status_fh=0.
REQ-034 Same with reg_ie0=1 -> int_n=0 at N+4; status1_read -> int_n=1 two cycles later.
REQ-035 reg_line_int=195, reg_vscroll=10: status_fh set on display line 185, not 195.
REQ-036 status1_read pulsed in the exact cycle status_fh is set -> status_fh remains 1.
REQ-037 reg_212lines=1, ie1=1: display line 212 -> status_f=1, int_n=0; status0_read -> both cleared; reg_212lines=0 -> set at 192.
REQ-038 reset asserted at display line 68 with reg_line_int=69, released next line -> no status_fh until line 69 of next frame.

Source files
------------

// File: rtl/vdp_package.sv
// Shared constants and helpers for the VDP interrupt controller slice.
// Line numbers are 9-bit to cover the full raw line range of a field.
package vdp_package;

  localparam logic [8:0] LINES_192           = 9'd192;
  localparam logic [8:0] LINES_212           = 9'd212;
  localparam logic [8:0] TOP_LINE_DEFAULT    = 9'd27;
  localparam logic [8:0] VBLANK_LINE_DEFAULT = LINES_212;
  localparam logic [8:0] RAW_LINE_MAX        = 9'd511;

  // Only the first 256 display lines can raise a line interrupt.
  function automatic logic line_match(
    input logic [8:0] display_line,
    input logic [7:0] vscroll,
    input logic [7:0] line_int
  );
    logic [7:0] scrolled;
    scrolled = display_line[7:0] + vscroll;
    return !display_line[8] && (scrolled == line_int);
  endfunction

endpackage

// File: rtl/vdp_line_counter.sv
// Raw line counter, display-relative line and the compare strobe that
// marks the cycle in which display_line holds a freshly started line.
module vdp_line_counter
  import vdp_package::*;
#(
  parameter logic [8:0] TOP_LINE = TOP_LINE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       line_start,
  output logic [8:0] display_line,
  output logic       line_strobe
);

  logic [8:0] raw_q, raw_d;
  logic [8:0] display_q, display_d;
  logic       event_q, event_d;
  logic       strobe_q, strobe_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    raw_d = raw_q;
    if (frame_start) begin
      raw_d = '0;
    end else if (line_start && (raw_q != RAW_LINE_MAX)) begin
      raw_d = raw_q + 9'd1;
    end
    display_d = raw_q - TOP_LINE;
    event_d   = frame_start | line_start;
    strobe_d  = event_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q     <= '0;
      display_q <= 9'd0 - TOP_LINE;
      event_q   <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      raw_q     <= raw_d;
      display_q <= display_d;
      event_q   <= event_d;
      strobe_q  <= strobe_d;
    end
  end

  assign display_line = display_q;
  assign line_strobe  = strobe_q;

endmodule

// File: rtl/vdp_interrupt_controller.sv
// Line (FH) and frame (F) interrupt flags with CPU read-clear and the
// registered active-low interrupt request to the slot.
module vdp_interrupt_controller
  import vdp_package::*;
#(
  parameter logic [8:0] TOP_LINE    = TOP_LINE_DEFAULT,
  parameter logic [8:0] VBLANK_LINE = VBLANK_LINE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       reg_ie0,
  input  logic       reg_ie1,
  input  logic       reg_212lines,
  input  logic [7:0] reg_line_int,
  input  logic [7:0] reg_vscroll,
  input  logic       status0_read,
  input  logic       status1_read,
  output logic       status_f,
  output logic       status_fh,
  output logic [8:0] display_line,
  output logic       int_n
);

  logic       line_strobe;
  logic [8:0] vblank_line;
  logic       line_hit, frame_hit;
  logic       status_f_q, status_f_d;
  logic       status_fh_q, status_fh_d;
  logic       int_n_q, int_n_d;

  vdp_line_counter #(
    .TOP_LINE (TOP_LINE)
  ) u_line_counter (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .display_line (display_line),
    .line_strobe  (line_strobe)
  );

  always_comb begin
    vblank_line = reg_212lines ? VBLANK_LINE : LINES_192;
    line_hit    = line_strobe && line_match(display_line, reg_vscroll, reg_line_int);
    frame_hit   = line_strobe && (display_line == vblank_line);

    // A set in the same cycle as a read-clear wins, so no event is lost.
    status_fh_d = status_fh_q;
    if (status1_read) status_fh_d = 1'b0;
    if (line_hit)     status_fh_d = 1'b1;

    status_f_d = status_f_q;
    if (status0_read) status_f_d = 1'b0;
    if (frame_hit)    status_f_d = 1'b1;

    int_n_d = ~((status_fh_q & reg_ie0) | (status_f_q & reg_ie1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_f_q  <= 1'b0;
      status_fh_q <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      status_f_q  <= status_f_d;
      status_fh_q <= status_fh_d;
      int_n_q     <= int_n_d;
    end
  end

  assign status_f  = status_f_q;
  assign status_fh = status_fh_q;
  assign int_n     = int_n_q;

endmodule

// File: tb/tb_vdp_interrupt_controller.sv
// Bench for vdp_interrupt_controller: directed scenarios plus random traffic,
// every cycle compared against a cycle-history reference model.
module tb_vdp_interrupt_controller;

  localparam int MAXC     = 32768;
  localparam int TOP      = 27;
  localparam int RST_DISP = 485;

  logic       clk = 1'b0;
  logic       reset, frame_start, line_start;
  logic       reg_ie0, reg_ie1, reg_212lines;
  logic [7:0] reg_line_int, reg_vscroll;
  logic       status0_read, status1_read;
  logic       status_f, status_fh, int_n;
  logic [8:0] display_line;

  int n_checks      = 0;
  int n_miscompares = 0;

  // Reference model: history of line events and resets by cycle, plus the
  // expected visible values for the current cycle.
  bit ev_hist [MAXC];
  bit rs_hist [MAXC];
  int cyc;
  int exp_raw, exp_disp;
  bit exp_f, exp_fh, exp_int_n;

  vdp_interrupt_controller dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .reg_ie0      (reg_ie0),
    .reg_ie1      (reg_ie1),
    .reg_212lines (reg_212lines),
    .reg_line_int (reg_line_int),
    .reg_vscroll  (reg_vscroll),
    .status0_read (status0_read),
    .status1_read (status1_read),
    .status_f     (status_f),
    .status_fh    (status_fh),
    .display_line (display_line),
    .int_n        (int_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  // Compare the current cycle, record its inputs, predict the next cycle,
  // then advance to just after the next rising edge and drop the pulses.
  task automatic tick();
    bit strobe, hit, vhit;
    int vb;
    bit n_f, n_fh, n_int_n;
    int n_raw, n_disp;
    @(negedge clk);
    check("display_line", display_line, 9'(exp_disp));
    check("status_f", 9'(status_f), 9'(exp_f));
    check("status_fh", 9'(status_fh), 9'(exp_fh));
    check("int_n", 9'(int_n), 9'(exp_int_n));
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    ev_hist[cyc] = line_start || frame_start;
    rs_hist[cyc] = reset;
    strobe = (cyc >= 2) && ev_hist[cyc-2] && !rs_hist[cyc-2] && !rs_hist[cyc-1];
    hit    = strobe && (exp_disp < 256) &&
             (((exp_disp + int'(reg_vscroll)) % 256) == int'(reg_line_int));
    vb     = reg_212lines ? 212 : 192;
    vhit   = strobe && (exp_disp == vb);

    if (reset) begin
      n_raw = 0; n_disp = RST_DISP; n_f = 0; n_fh = 0; n_int_n = 1;
    end else begin
      if (frame_start)     n_raw = 0;
      else if (line_start) n_raw = (exp_raw >= 511) ? 511 : exp_raw + 1;
      else                 n_raw = exp_raw;
      n_disp  = (exp_raw + 512 - TOP) % 512;
      n_fh    = hit  ? 1'b1 : (status1_read ? 1'b0 : exp_fh);
      n_f     = vhit ? 1'b1 : (status0_read ? 1'b0 : exp_f);
      n_int_n = !((exp_fh && reg_ie0) || (exp_f && reg_ie1));
    end
    exp_raw = n_raw; exp_disp = n_disp;
    exp_f = n_f; exp_fh = n_fh; exp_int_n = n_int_n;

    @(posedge clk);
    #1;
    cyc++;
    line_start   = 1'b0;
    frame_start  = 1'b0;
    status0_read = 1'b0;
    status1_read = 1'b0;
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_start = 1'b1;
      tick();
      repeat (3) tick();
    end
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    tick();
    repeat (3) tick();
  endtask

  task automatic clear_flags();
    status0_read = 1'b1;
    status1_read = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    reg_ie0 = 1'b0; reg_ie1 = 1'b0; reg_212lines = 1'b1;
    reg_line_int = 8'd69; reg_vscroll = 8'd0;
    status0_read = 1'b0; status1_read = 1'b0;

    @(posedge clk);
    #1;
    cyc = 1; rs_hist[0] = 1'b1; ev_hist[0] = 1'b0;
    exp_raw = 0; exp_disp = RST_DISP; exp_f = 0; exp_fh = 0; exp_int_n = 1;

    check("rst_display_line", display_line, 9'd485);
    check("rst_status_f", 9'(status_f), 9'd0);
    check("rst_status_fh", 9'(status_fh), 9'd0);
    check("rst_int_n", 9'(int_n), 9'd1);
    tick();
    reset = 1'b0;

    // Line 69 match without line interrupt enable.
    new_frame();
    run_lines(TOP + 68);
    line_start = 1'b1;
    tick(); tick();
    check("l69_disp_n2", display_line, 9'd69);
    check("l69_fh_n2", 9'(status_fh), 9'd0);
    tick();
    check("l69_fh_n3", 9'(status_fh), 9'd1);
    tick();
    check("l69_intn_ie0off", 9'(int_n), 9'd1);
    status1_read = 1'b1;
    tick();
    check("l69_fh_cleared", 9'(status_fh), 9'd0);

    // Same line with the line interrupt enabled.
    reg_ie0 = 1'b1;
    new_frame();
    run_lines(TOP + 68);
    line_start = 1'b1;
    repeat (3) tick();
    check("ie0_intn_n3", 9'(int_n), 9'd1);
    tick();
    check("ie0_intn_n4", 9'(int_n), 9'd0);
    status1_read = 1'b1;
    tick();
    check("ie0_fh_read1", 9'(status_fh), 9'd0);
    check("ie0_intn_read1", 9'(int_n), 9'd0);
    tick();
    check("ie0_intn_read2", 9'(int_n), 9'd1);
    reg_ie0 = 1'b0;

    // Read-clear colliding with the set cycle: the set wins.
    new_frame();
    run_lines(TOP + 68);
    line_start = 1'b1;
    tick(); tick();
    status1_read = 1'b1;
    tick();
    check("collide_fh_kept", 9'(status_fh), 9'd1);
    clear_flags();

    // Vertical scroll shifts the matching display line.
    reg_line_int = 8'd195; reg_vscroll = 8'd10;
    new_frame();
    run_lines(TOP + 185);
    check("vscroll_fh_185", 9'(status_fh), 9'd1);
    status1_read = 1'b1;
    tick();
    run_lines(12);
    check("vscroll_no_fh_195", 9'(status_fh), 9'd0);

    // Frame flag at line 212, then at 192.
    reg_line_int = 8'd250; reg_vscroll = 8'd0; reg_ie1 = 1'b1; reg_212lines = 1'b1;
    new_frame();
    run_lines(TOP + 211);
    check("f212_before", 9'(status_f), 9'd0);
    line_start = 1'b1;
    repeat (3) tick();
    check("f212_set", 9'(status_f), 9'd1);
    tick();
    check("f212_intn", 9'(int_n), 9'd0);
    status0_read = 1'b1;
    tick();
    check("f212_read_f", 9'(status_f), 9'd0);
    tick();
    check("f212_read_intn", 9'(int_n), 9'd1);
    reg_212lines = 1'b0;
    new_frame();
    run_lines(TOP + 191);
    check("f192_before", 9'(status_f), 9'd0);
    line_start = 1'b1;
    repeat (3) tick();
    check("f192_set", 9'(status_f), 9'd1);
    reg_ie1 = 1'b0;
    tick(); tick();
    check("f192_ie1_off_intn", 9'(int_n), 9'd1);
    check("f192_ie1_off_flag", 9'(status_f), 9'd1);
    clear_flags();
    reg_212lines = 1'b1;

    // frame_start and line_start together: frame_start wins.
    frame_start = 1'b1; line_start = 1'b1;
    tick(); tick();
    check("frame_prio_disp", display_line, 9'd485);
    repeat (2) tick();

    // Reset mid-frame discards the in-flight line 69 match.
    reg_line_int = 8'd69;
    new_frame();
    run_lines(TOP + 68);
    line_start = 1'b1;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("rst_inflight_fh", 9'(status_fh), 9'd0);
    run_lines(10);
    check("rst_after_lines_fh", 9'(status_fh), 9'd0);
    new_frame();
    run_lines(TOP + 70);
    check("rst_next_frame_fh", 9'(status_fh), 9'd1);
    clear_flags();

    // Random traffic; frames run to saturation in the first half.
    for (int i = 0; i < 9000; i++) begin
      if (i % 400 == 0) begin
        reg_line_int = 8'($urandom_range(0, 255));
        reg_vscroll  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
        reg_ie0      = 1'($urandom_range(0, 1));
        reg_ie1      = 1'($urandom_range(0, 1));
        reg_212lines = 1'($urandom_range(0, 1));
      end
      line_start   = ($urandom_range(0, 3) == 0);
      frame_start  = ((i > 4500) && (exp_raw >= 262)) || ($urandom_range(0, 2999) == 0);
      status0_read = ($urandom_range(0, 15) == 0);
      status1_read = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 3999) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
